conv_3x3: RTL and testbench

- Streaming 3x3 2-D convolution (correlation) engine for 8-bit signed pixels and weights.
- Kernel and image both arrive column by column: three row values per accepted beat.
- Image columns shift through a 3-column sliding window; each completed window yields one registered signed sum of 9 products.
- Sits between a column-feeding front end and downstream accumulation/activation logic.

---
 rtl/conv_pkg.sv | 21 ++
 rtl/conv_dot9.sv | 21 ++
 rtl/conv_3x3.sv | 86 ++++++++
 tb/tb_conv_3x3.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared widths and types for the streaming 3x3 convolution engine.
package conv_pkg;

  localparam int unsigned BIT_LEN  = 8;
  localparam int unsigned M_LEN    = 3;
  localparam int unsigned CONV_LEN = 20;

  typedef logic signed [BIT_LEN-1:0]   pixel_t;
  typedef logic signed [2*BIT_LEN-1:0] prod_t;
  typedef logic signed [CONV_LEN-1:0]  acc_t;
  typedef pixel_t column_t [M_LEN];

  // Image columns received since reset or since the last kernel beat.
  typedef enum logic [1:0] {
    FILL_0,
    FILL_1,
    FILL_2,
    FILL_FULL
  } fill_e;

endpackage

// File: rtl/conv_dot9.sv
// Combinational 9-term signed multiply-add of kernel and window, indexed [column][row].
module conv_dot9
  import conv_pkg::*;
(
  input  column_t kern [M_LEN],
  input  column_t win  [M_LEN],
  output acc_t    sum
);

  always_comb begin
    sum = '0;
    for (int unsigned c = 0; c < M_LEN; c++) begin
      for (int unsigned r = 0; r < M_LEN; r++) begin
        prod_t prod;
        prod = kern[c][r] * win[c][r];
        sum  = sum + acc_t'(prod);
      end
    end
  end

endmodule

// File: rtl/conv_3x3.sv
// Streaming 3x3 correlation: column-wise kernel/image shift registers and a registered 9-term sum.
module conv_3x3
  import conv_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_valid,
  input  logic                       i_selecK_I,
  input  logic signed [BIT_LEN-1:0]  i_data0,
  input  logic signed [BIT_LEN-1:0]  i_data1,
  input  logic signed [BIT_LEN-1:0]  i_data2,
  output logic signed [CONV_LEN-1:0] o_data
);

  column_t kern [M_LEN];
  column_t win  [M_LEN];
  column_t in_col;
  fill_e   fill, fill_next;
  logic    pending, pending_next;
  acc_t    dot;

  always_comb begin
    in_col[0] = i_data0;
    in_col[1] = i_data1;
    in_col[2] = i_data2;
  end

  conv_dot9 u_dot9 (
    .kern (kern),
    .win  (win),
    .sum  (dot)
  );

  // Kernel beats restart window fill; once full, every image beat completes a window.
  always_comb begin
    fill_next    = fill;
    pending_next = 1'b0;
    if (i_valid) begin
      if (!i_selecK_I) begin
        fill_next = FILL_0;
      end else begin
        case (fill)
          FILL_0:  fill_next = FILL_1;
          FILL_1:  fill_next = FILL_2;
          FILL_2:  fill_next = FILL_FULL;
          default: fill_next = FILL_FULL;
        endcase
        pending_next = (fill_next == FILL_FULL);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      for (int unsigned c = 0; c < M_LEN; c++) begin
        for (int unsigned r = 0; r < M_LEN; r++) begin
          kern[c][r] <= '0;
          win[c][r]  <= '0;
        end
      end
      fill    <= FILL_0;
      pending <= 1'b0;
      o_data  <= '0;
    end else begin
      fill    <= fill_next;
      pending <= pending_next;
      // Uses the registers as they stood before any shift on this same edge.
      if (pending) begin
        o_data <= dot;
      end
      if (i_valid && !i_selecK_I) begin
        for (int unsigned c = 0; c < M_LEN - 1; c++) begin
          kern[c] <= kern[c+1];
        end
        kern[M_LEN-1] <= in_col;
      end
      if (i_valid && i_selecK_I) begin
        for (int unsigned c = 0; c < M_LEN - 1; c++) begin
          win[c] <= win[c+1];
        end
        win[M_LEN-1] <= in_col;
      end
    end
  end

endmodule

// File: tb/tb_conv_3x3.sv
// Directed and random stimulus for conv_3x3 against a queue-based column model.
module tb_conv_3x3;
  import conv_pkg::*;

  logic                       i_clk;
  logic                       i_reset;
  logic                       i_valid;
  logic                       i_selecK_I;
  logic signed [BIT_LEN-1:0]  i_data0;
  logic signed [BIT_LEN-1:0]  i_data1;
  logic signed [BIT_LEN-1:0]  i_data2;
  logic signed [CONV_LEN-1:0] o_data;

  conv_3x3 dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_valid    (i_valid),
    .i_selecK_I (i_selecK_I),
    .i_data0    (i_data0),
    .i_data1    (i_data1),
    .i_data2    (i_data2),
    .o_data     (o_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    int r [3];
  } col_s;

  col_s kq [$];
  col_s wq [$];
  int   img_cols;
  bit   due;
  acc_t exp_out;

  int n_assert = 0;
  int n_fail   = 0;

  function automatic col_s mk_col(int a, int b, int c);
    col_s x;
    x.r[0] = a;
    x.r[1] = b;
    x.r[2] = c;
    return x;
  endfunction

  function automatic int rnd_px();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  function automatic acc_t model_sum();
    int s = 0;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++)
        s += kq[c].r[r] * wq[c].r[r];
    return acc_t'(s);
  endfunction

  task automatic model_clear();
    kq.delete();
    wq.delete();
    repeat (3) begin
      kq.push_back(mk_col(0, 0, 0));
      wq.push_back(mk_col(0, 0, 0));
    end
    img_cols = 0;
    due      = 1'b0;
    exp_out  = '0;
  endtask

  // One clock edge of the reference: result from the window completed on the previous edge,
  // then this edge's beat appended as the newest column.
  task automatic model_edge(bit rst, bit v, bit sel, int a, int b, int c);
    bit due_now;
    if (!rst) begin
      model_clear();
    end else begin
      if (due) exp_out = model_sum();
      due_now = 1'b0;
      if (v && !sel) begin
        kq.push_back(mk_col(a, b, c));
        void'(kq.pop_front());
        img_cols = 0;
      end else if (v && sel) begin
        wq.push_back(mk_col(a, b, c));
        void'(wq.pop_front());
        img_cols = (img_cols < 3) ? img_cols + 1 : 3;
        due_now  = (img_cols == 3);
      end
      due = due_now;
    end
  endtask

  task automatic check(string tag, acc_t want);
    n_assert++;
    assert (o_data === want)
    else begin
      n_fail++;
      $error("FAIL %s: o_data=%0d expected %0d", tag, o_data, want);
    end
  endtask

  task automatic step(bit rst, bit v, bit sel, int a, int b, int c, string tag);
    i_reset    = rst;
    i_valid    = v;
    i_selecK_I = sel;
    i_data0    = BIT_LEN'(a);
    i_data1    = BIT_LEN'(b);
    i_data2    = BIT_LEN'(c);
    @(posedge i_clk);
    #1;
    model_edge(rst, v, sel, a, b, c);
    check(tag, exp_out);
  endtask

  task automatic kbeat(int p, string tag);
    step(1'b1, 1'b1, 1'b0, p, p, p, tag);
  endtask

  task automatic ibeat(int p, string tag);
    step(1'b1, 1'b1, 1'b1, p, p, p, tag);
  endtask

  task automatic idle(string tag);
    step(1'b1, 1'b0, 1'($urandom_range(0, 1)), rnd_px(), rnd_px(), rnd_px(), tag);
  endtask

  initial begin
    model_clear();
    i_reset = 1'b0; i_valid = 1'b0; i_selecK_I = 1'b0;
    i_data0 = '0; i_data1 = '0; i_data2 = '0;

    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           rnd_px(), rnd_px(), rnd_px(), "reset_hold");
      check("reset_zero", '0);
    end
    idle("reset_release");
    check("release_zero", '0);

    kbeat(1, "k1"); kbeat(2, "k2"); kbeat(3, "k3");
    ibeat(1, "fill_i1"); check("no_update_i1", '0);
    ibeat(2, "fill_i2"); check("no_update_i2", '0);
    ibeat(3, "fill_i3"); check("pending_edge", '0);
    idle("fill_result"); check("fill_42", 42);

    ibeat(4, "slide4"); idle("slide4_res"); check("slide_60", 60);
    ibeat(5, "slide5");
    ibeat(6, "slide6"); check("b2b_78", 78);
    idle("slide6_res"); check("b2b_96", 96);
    idle("hold"); check("hold_96", 96);

    kbeat(-1, "kneg1"); kbeat(-1, "kneg2"); kbeat(-1, "kneg3");
    ibeat(-128, "im80_1"); ibeat(-128, "im80_2"); ibeat(-128, "im80_3");
    idle("signed_res"); check("signed_1152", 1152);

    kbeat(-128, "k80_1"); kbeat(-128, "k80_2"); kbeat(-128, "k80_3");
    ibeat(-128, "im80b_1"); ibeat(-128, "im80b_2"); ibeat(-128, "im80b_3");
    idle("max_res"); check("max_147456", 147456);

    kbeat(1, "reload_k");
    ibeat(1, "reload_i1"); check("reload_hold1", 147456);
    ibeat(1, "reload_i2"); check("reload_hold2", 147456);
    ibeat(1, "reload_i3");
    idle("reload_res"); check("reload_new", -765);

    ibeat(7, "mid_img");
    step(1'b0, 1'b1, 1'b1, 9, 9, 9, "mid_reset"); check("mid_reset_zero", '0);
    ibeat(3, "post_i1"); ibeat(4, "post_i2"); ibeat(5, "post_i3");
    idle("post_res"); check("zero_kernel_after_reset", '0);
    kbeat(0, "kz1"); kbeat(0, "kz2"); kbeat(0, "kz3");
    ibeat(rnd_px(), "z_i1"); ibeat(rnd_px(), "z_i2"); ibeat(rnd_px(), "z_i3");
    idle("z_res"); check("zero_kernel_res", '0);

    for (int i = 0; i < 400; i++) begin
      bit rst_n = ($urandom_range(0, 99) >= 2);
      bit v     = ($urandom_range(0, 3) != 0);
      bit sel   = ($urandom_range(0, 2) != 0);
      step(rst_n, v, sel, rnd_px(), rnd_px(), rnd_px(), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
